// File: rtl/mc_controller.sv
// Multicycle control FSM for the 16-bit datapath.
// It sequences fetch, decode, execute and writeback for each instruction.
// It drives every datapath mux select and enable.
// Memory states wait on mem_ready. WAIT counts down a register operand.
// Illegal extended opcodes trap in HALT, and only reset leaves HALT.
module mc_controller #(
  parameter int WAIT_W = 29
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        op,
  input  logic [3:0]        op_ext,
  input  logic [3:0]        branch_cond,
  input  logic [4:0]        psr,
  input  logic [WAIT_W-1:0] wait_count,
  input  logic              mem_ready,
  output logic [1:0]        WD_S,
  output logic [1:0]        ALUA_S,
  output logic [1:0]        ALUB_S,
  output logic [1:0]        MEM_S,
  output logic              MEM_DATA_S,
  output logic              PC_S,
  output logic              PC_EN,
  output logic              REG_WR_EN,
  output logic              INSTR_EN,
  output logic              ALU_OUT_EN,
  output logic              MEM_REG_EN,
  output logic              MEM_WR,
  output logic              SE_SIGN,
  output logic              PSR_EN,
  output logic              MEM_REQ,
  output logic              halted,
  output logic [4:0]        state_o
);

  typedef enum logic [4:0] {
    S_FETCH      = 5'b00000,
    S_DECODE     = 5'b00001,
    S_RTYPE_EX   = 5'b00010,
    S_ITYPE_EX   = 5'b00011,
    S_WRITE      = 5'b00100,
    S_LB_MEM     = 5'b00101,
    S_LB_LOAD    = 5'b00110,
    S_SB_MEM_R   = 5'b00111,
    S_CALC_DISP  = 5'b01010,
    S_JUMP       = 5'b01011,
    S_CALC_RLINK = 5'b01100,
    S_WR_RLINK_J = 5'b01101,
    S_PC_UP      = 5'b01110,
    S_SB_MEM_I   = 5'b01111,
    S_WAIT       = 5'b10000,
    S_HALT       = 5'b11111
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              take;

  // Branch condition on flags {N,Z,F,L,C}. Signed compares use N, unsigned compares use L.
  function automatic logic cond_take(input logic [3:0] c, input logic [4:0] f);
    logic n, z, fl, l, cy;
    logic r;
    n  = f[4];
    z  = f[3];
    fl = f[2];
    l  = f[1];
    cy = f[0];
    case (c)
      4'h0:    r = z;
      4'h1:    r = !z;
      4'h2:    r = cy;
      4'h3:    r = !cy;
      4'h4:    r = l;
      4'h5:    r = !l;
      4'h6:    r = n;
      4'h7:    r = !n;
      4'h8:    r = fl;
      4'h9:    r = !fl;
      4'hA:    r = !l && !z;
      4'hB:    r = l || z;
      4'hC:    r = !n && !z;
      4'hD:    r = n || z;
      4'hE:    r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // State register and WAIT down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The counter loads wait_count once, on the cycle that enters WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = cond_take(branch_cond, psr);
    case (state_q)
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          4'b0000: state_d = S_RTYPE_EX;
          4'b0100: begin
            case (op_ext)
              4'b0100: state_d = S_SB_MEM_R;
              4'b0000: state_d = S_LB_MEM;
              4'b1100: state_d = take ? S_JUMP : S_PC_UP;
              4'b1000: state_d = S_CALC_RLINK;
              default: state_d = S_HALT;
            endcase
          end
          4'b1000: state_d = (op_ext == 4'b0100) ? S_RTYPE_EX : S_ITYPE_EX;
          4'b1100: state_d = take ? S_CALC_DISP : S_PC_UP;
          default: state_d = S_ITYPE_EX;
        endcase
      end
      S_RTYPE_EX: begin
        if (op_ext == 4'b1011) begin
          state_d = S_PC_UP;
        end else if (op_ext == 4'b0000) begin
          state_d = S_WAIT;
          cnt_d   = wait_count;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_ITYPE_EX: begin
        if (op == 4'b1011)      state_d = S_PC_UP;
        else if (op == 4'b0111) state_d = S_SB_MEM_I;
        else                    state_d = S_WRITE;
      end
      S_WRITE:      state_d = S_PC_UP;
      S_LB_MEM:     if (mem_ready) state_d = S_LB_LOAD;
      S_LB_LOAD:    state_d = S_PC_UP;
      S_SB_MEM_R:   if (mem_ready) state_d = S_PC_UP;
      S_SB_MEM_I:   if (mem_ready) state_d = S_PC_UP;
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_PC_UP;
        else             cnt_d   = cnt_q - WAIT_W'(1);
      end
      S_CALC_DISP:  state_d = S_FETCH;
      S_JUMP:       state_d = S_FETCH;
      S_CALC_RLINK: state_d = S_WR_RLINK_J;
      S_WR_RLINK_J: state_d = S_FETCH;
      S_PC_UP:      state_d = S_FETCH;
      S_HALT:       state_d = S_HALT;
      default:      state_d = S_HALT;
    endcase
  end

  // Moore outputs per state. The *_EN strobes of the memory states are gated by mem_ready.
  // Reset forces every output to its default, so an in-flight store never commits.
  always_comb begin
    WD_S       = 2'b00;
    ALUA_S     = 2'b00;
    ALUB_S     = 2'b00;
    MEM_S      = 2'b00;
    MEM_DATA_S = 1'b0;
    PC_S       = 1'b0;
    PC_EN      = 1'b0;
    REG_WR_EN  = 1'b0;
    INSTR_EN   = 1'b0;
    ALU_OUT_EN = 1'b0;
    MEM_REG_EN = 1'b0;
    MEM_WR     = 1'b0;
    SE_SIGN    = 1'b1;
    PSR_EN     = 1'b0;
    MEM_REQ    = 1'b0;
    halted     = 1'b0;
    state_o    = 5'b00000;
    if (!reset) begin
      state_o = state_q;
      case (state_q)
        S_FETCH: begin
          MEM_S    = 2'b01;
          MEM_REQ  = 1'b1;
          INSTR_EN = mem_ready;
        end
        S_RTYPE_EX: begin
          ALU_OUT_EN = 1'b1;
          PSR_EN     = 1'b1;
        end
        S_ITYPE_EX: begin
          ALUA_S     = 2'b10;
          ALU_OUT_EN = 1'b1;
          PSR_EN     = 1'b1;
          if (op == 4'b0001 || op == 4'b0010 || op == 4'b0011) SE_SIGN = 1'b0;
        end
        S_WRITE: begin
          WD_S      = 2'b11;
          REG_WR_EN = 1'b1;
        end
        S_LB_MEM: begin
          WD_S       = 2'b10;
          MEM_REQ    = 1'b1;
          MEM_REG_EN = mem_ready;
        end
        S_LB_LOAD: begin
          WD_S      = 2'b10;
          REG_WR_EN = 1'b1;
        end
        S_SB_MEM_R: begin
          MEM_REQ    = 1'b1;
          MEM_WR     = 1'b1;
          MEM_DATA_S = 1'b0;
        end
        S_SB_MEM_I: begin
          MEM_S      = 2'b10;
          MEM_REQ    = 1'b1;
          MEM_WR     = 1'b1;
          MEM_DATA_S = 1'b1;
        end
        S_CALC_DISP: begin
          ALUA_S = 2'b01;
          ALUB_S = 2'b01;
          PC_S   = 1'b1;
          PC_EN  = 1'b1;
        end
        S_JUMP: PC_EN = 1'b1;
        S_CALC_RLINK: begin
          ALUA_S     = 2'b01;
          ALUB_S     = 2'b10;
          ALU_OUT_EN = 1'b1;
        end
        S_WR_RLINK_J: begin
          WD_S      = 2'b11;
          REG_WR_EN = 1'b1;
          PC_EN     = 1'b1;
        end
        S_PC_UP: begin
          ALUA_S = 2'b01;
          ALUB_S = 2'b10;
          PC_S   = 1'b1;
          PC_EN  = 1'b1;
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Parametrised multicycle control FSM for the 16-bit datapath, succeeding the fixed-timing controller. Sequences fetch/decode/execute/writeback per instruction and drives all datapath mux selects and enables. It adds three behaviours:
- a variable-latency memory handshake (`mem_ready`);
- a programmable WAIT duration taken from a register operand, with configurable counter width;
- an illegal-opcode HALT trap with an observable status output.

## Interface
- `WAIT_W`, 29: width of the WAIT down-counter and of `wait_count`.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `op`  in  4  instruction opcode [15:12].
- `op_ext`  in  4  opcode extension [7:4].
- `branch_cond`  in  4  condition field [11:8].
- `psr`  in  5  flags {N,Z,F,L,C} (bit4..bit0).
- `wait_count`  in  WAIT_W  WAIT duration operand; sampled on RTYPE_EX→WAIT.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `WD_S`, `ALUA_S`, `ALUB_S`, `MEM_S`  out  2 each  datapath selects.
- `MEM_DATA_S`, `PC_S`, `PC_EN`, `REG_WR_EN`, `INSTR_EN`, `ALU_OUT_EN`, `MEM_REG_EN`, `MEM_WR`, `SE_SIGN`, `PSR_EN`  out  1 each  datapath controls.
- `MEM_REQ`  out  1  memory access requested.
- `halted`  out  1  controller trapped in HALT.
- `state_o`  out  5  current state encoding, for debug.

## Operation
- State encodings:
  - FETCH=00000, DECODE=00001, RTYPE_EX=00010, ITYPE_EX=00011, WRITE=00100
  - LB_MEM=00101, LB_LOAD=00110, SB_MEM_R=00111, SB_MEM_I=01111
  - CALC_DISP=01010, JUMP=01011, CALC_RLINK=01100, WR_RLINK_J=01101, PC_UP=01110
  - WAIT=10000, HALT=11111
- Condition evaluation is internal (`take`), indexed by `branch_cond`:
  - 0 Z; 1 !Z; 2 C; 3 !C; 4 L; 5 !L; 6 N; 7 !N
  - 8 F; 9 !F; A !L&!Z; B L|Z; C !N&!Z; D N|Z
  - E always; F never
- Transitions:
  - FETCH→DECODE when `mem_ready`, else stay.
  - DECODE on `op`:
    - 0000: RTYPE_EX.
    - 0100: by `op_ext`. 0100→SB_MEM_R; 0000→LB_MEM; 1100→JUMP if `take`, else PC_UP; 1000→CALC_RLINK; any other→HALT.
    - 1000: `op_ext`=0100→RTYPE_EX, else ITYPE_EX.
    - 1100: CALC_DISP if `take`, else PC_UP.
    - Any other: ITYPE_EX.
  - RTYPE_EX on `op_ext`: 1011→PC_UP; 0000→WAIT (counter loads `wait_count`); else→WRITE.
  - ITYPE_EX on `op`: 1011→PC_UP; 0111→SB_MEM_I; else→WRITE.
  - WRITE→PC_UP.
  - LB_MEM→LB_LOAD when `mem_ready`, else stay. LB_LOAD→PC_UP.
  - SB_MEM_R and SB_MEM_I→PC_UP when `mem_ready`, else stay.
  - WAIT: if counter==0→PC_UP, else decrement and stay.
  - CALC_DISP, JUMP, WR_RLINK_J, PC_UP→FETCH. CALC_RLINK→WR_RLINK_J.
  - HALT→HALT; only `reset` exits.
- Outputs are Moore except the `mem_ready`-gated enables. Defaults: all 0, SE_SIGN=1. Per state:
  - FETCH: MEM_S=01, MEM_REQ=1, INSTR_EN=`mem_ready`.
  - RTYPE_EX: ALU_OUT_EN=1, PSR_EN=1.
  - ITYPE_EX: ALUA_S=10, ALU_OUT_EN=1, PSR_EN=1. SE_SIGN=0 when `op`∈{0001,0010,0011}.
  - WRITE: WD_S=11, REG_WR_EN=1.
  - LB_MEM: WD_S=10, MEM_REQ=1, MEM_REG_EN=`mem_ready`.
  - LB_LOAD: WD_S=10, REG_WR_EN=1.
  - SB_MEM_R: MEM_REQ=1, MEM_WR=1, MEM_DATA_S=0.
  - SB_MEM_I: MEM_S=10, MEM_REQ=1, MEM_WR=1, MEM_DATA_S=1.
  - CALC_DISP: ALUA_S=01, ALUB_S=01, PC_S=1, PC_EN=1.
  - JUMP: PC_EN=1.
  - CALC_RLINK: ALUA_S=01, ALUB_S=10, ALU_OUT_EN=1.
  - WR_RLINK_J: WD_S=11, REG_WR_EN=1, PC_EN=1.
  - PC_UP: ALUA_S=01, ALUB_S=10, PC_S=1, PC_EN=1.
  - HALT: halted=1.
- Store handshake: the store commits in the cycle MEM_WR=1 and `mem_ready`=1. The store request is held stable until then.

## Timing
- Reset: on a `clk` edge with `reset`=1, state←FETCH and counter←0.
  - While `reset` is high, all outputs are forced to defaults: MEM_REQ=0, halted=0, `state_o`=00000.
  - Reset mid-access aborts the access with no commit. Reset in HALT or WAIT returns to FETCH.
- Cycle counts with `mem_ready` tied 1:
  - R-type ALU: 5. I-type ALU: 5. CMP: 4.
  - LB: 5. SB: 4.
  - Bcond: 3 taken or not taken. Jcond taken: 3.
  - JAL: 4.
- Each memory state is extended by exactly the number of cycles `mem_ready` is low.
- WAIT occupies `wait_count`+1 cycles. `wait_count` is sampled once on entry; later changes are ignored.
- Branch decisions use `psr` and `branch_cond` as sampled in DECODE.
- `mem_ready` asserted outside a memory state is ignored.

## Test plan
- R-type ADD (`op`=0000, `op_ext`=0101), `mem_ready`=1 → states 0,1,2,4,14; REG_WR_EN=1 only in cycle 4, PC_EN=1 only in cycle 5.
- LB with `mem_ready` low for 3 cycles in LB_MEM → LB_MEM held 4 cycles; MEM_REG_EN pulses once, in the 4th; then LB_LOAD with REG_WR_EN=1.
- Bcond `branch_cond`=0000, `psr`=01000 → CALC_DISP. Same with `psr`=00000 → PC_UP. Code 1111 → never taken. Code 1110 → always taken.
- WAIT (`op`=0000, `op_ext`=0000) with `wait_count`=5, WAIT_W=8 → exactly 6 WAIT cycles, then PC_UP. `wait_count`=0 → 1 cycle.
- `op`=0100, `op_ext`=0111 → HALT, halted=1 indefinitely, no PC_EN. Assert `reset` → next cycle FETCH, halted=0.
- Assert `reset` during SB_MEM_I with `mem_ready`=0 → MEM_WR=0 immediately; FETCH after release; no store commits.
